// File: rtl/tug_field_if.sv
// Tug-of-war playfield bundle: key pulses in, field lights and counter qualifiers out.
interface tug_field_if #(
  parameter int NUM_LEDS = 9
);
  logic                L;
  logic                R;
  logic [NUM_LEDS-1:0] leds;
  logic                edge_armed;
  logic                side;
  logic                win_l;
  logic                win_r;
  logic                game_over;

  modport master (
    output L, R,
    input  leds, edge_armed, side, win_l, win_r, game_over
  );

  modport slave (
    input  L, R,
    output leds, edge_armed, side, win_l, win_r, game_over
  );
endinterface

// File: rtl/tug_field.sv
// Tug-of-war playfield: moves the rope light, flags edge wins, blanks then re-centres.
// Optional TUG_FIELD_MATCH_LIMIT_EN locks the field once either side reaches seven wins.
module tug_field #(
  parameter int NUM_LEDS    = 9,
  parameter int HOLD_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  tug_field_if.slave bus
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0] CENTER = PW'((NUM_LEDS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LEDS - 1);
  localparam logic [HW-1:0] HLAST  = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] PLAY   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold_cnt;
  logic          win_l_q;
  logic          win_r_q;

  logic play;
  logic at_left;
  logic at_right;
  logic go_l;
  logic go_r;
  logic lock_next;

  assign play     = (state == PLAY);
  assign at_left  = (pos == LAST);
  assign at_right = (pos == '0);
  assign go_l     = bus.L & ~bus.R;
  assign go_r     = bus.R & ~bus.L;

`ifdef TUG_FIELD_MATCH_LIMIT_EN
  logic [2:0] tally_l;
  logic [2:0] tally_r;

  // Tallies advance on the winning edge so HOLD exit sees them even when HOLD is one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tally_l <= '0;
      tally_r <= '0;
    end else if (play) begin
      if (go_l && at_left && tally_l != 3'd7)
        tally_l <= tally_l + 3'd1;
      if (go_r && at_right && tally_r != 3'd7)
        tally_r <= tally_r + 3'd1;
    end
  end

  assign lock_next     = (tally_l == 3'd7) | (tally_r == 3'd7);
  assign bus.game_over = (state == LOCKED);
`else
  assign lock_next     = 1'b0;
  assign bus.game_over = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PLAY;
      pos      <= CENTER;
      hold_cnt <= '0;
      win_l_q  <= 1'b0;
      win_r_q  <= 1'b0;
    end else begin
      win_l_q <= 1'b0;
      win_r_q <= 1'b0;
      unique case (state)
        PLAY: begin
          unique case (1'b1)
            go_l & at_left: begin
              win_l_q  <= 1'b1;
              state    <= HOLD;
              hold_cnt <= '0;
            end
            go_l & ~at_left:  pos <= pos + 1'b1;
            go_r & at_right: begin
              win_r_q  <= 1'b1;
              state    <= HOLD;
              hold_cnt <= '0;
            end
            go_r & ~at_right: pos <= pos - 1'b1;
            default: ;
          endcase
        end
        HOLD: begin
          if (hold_cnt == HLAST) begin
            state    <= lock_next ? LOCKED : PLAY;
            pos      <= CENTER;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LOCKED: ;
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.leds       = play ? ({{(NUM_LEDS-1){1'b0}}, 1'b1} << pos)
                               : '0;
  assign bus.edge_armed = play & (at_left | at_right);
  assign bus.side       = play & at_right;
  assign bus.win_l      = win_l_q;
  assign bus.win_r      = win_r_q;
endmodule

// File: doc/tug_field.md
Name: tug_field

Overview:
- Playfield controller for the two-player tug-of-war game. It sits directly upstream of the per-player 7-segment win counters.
- Consumes conditioned single-cycle key pulses L/R, moves a one-hot "rope" light across the LED row, and detects when a player wins.
- Produces edge_armed (drives the counters' CL) and side (drives the counters' i). The winning-press cycle, qualified by these, increments exactly one counter exactly once.

Parameters:
- NUM_LEDS, 9, number of playfield LEDs; odd, >= 3.
- HOLD_CYCLES, 4, cycles the field stays blank after a win before re-centring; >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- L  input  1  left-player press, single-cycle pulse, already synchronized/edge-detected upstream
- R  input  1  right-player press, single-cycle pulse, same conditioning
- leds  output  NUM_LEDS  playfield lights; leds[0] = rightmost, leds[NUM_LEDS-1] = leftmost
- edge_armed  output  1  light is on an edge LED and play is live (to counter CL)
- side  output  1  1 = right edge (pos 0), 0 = left edge (pos NUM_LEDS-1); to counter i; 0 when not armed
- win_l  output  1  one-cycle pulse, left player won
- win_r  output  1  one-cycle pulse, right player won
- game_over  output  1  high while LOCKED (optional feature only; tied 0 otherwise)

Behaviour:
- Registers:
  - pos: width $clog2(NUM_LEDS); reset value CENTER = (NUM_LEDS-1)/2 (4 for default).
  - state: PLAY / HOLD / LOCKED.
  - hold_cnt: width $clog2(HOLD_CYCLES+1).
- Reset (synchronous): state=PLAY, pos=CENTER, hold_cnt=0. Outputs from the first cycle after reset: leds=one-hot CENTER, edge_armed=0, side=0, win_l=win_r=0, game_over=0. Reset overrides all other activity, including during HOLD or LOCKED.
- leds: one-hot at pos in PLAY; all zeros in HOLD and LOCKED.
- edge_armed and side: combinational from registered state/pos.
  - edge_armed = (state==PLAY) & (pos==0 | pos==NUM_LEDS-1).
  - side = (state==PLAY) & (pos==0).
- PLAY transitions, evaluated at each clk:
  - L & R both high: no move, no win.
  - L only, pos<NUM_LEDS-1: pos+1.
  - L only, pos==NUM_LEDS-1: win_l=1 next cycle, state->HOLD, hold_cnt=0.
  - R only, pos>0: pos-1.
  - R only, pos==0: win_r=1 next cycle, state->HOLD, hold_cnt=0.
  - Press toward the opposite side while on an edge moves the light normally (e.g. R at pos NUM_LEDS-1 -> pos NUM_LEDS-2).
  - Neither pressed: hold.
- Downstream single-count guarantee:
  - edge_armed/side are valid in the same cycle the winning press is present, so the counter samples CL&i&R (or CL&~i&L) once.
  - The next cycle state is HOLD, so edge_armed=0 and no double count is possible even if the press were held.
- win_l/win_r: registered one-cycle pulses asserted in the first HOLD cycle. They are never both high.
- HOLD: L/R ignored. hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1, the next state is PLAY with pos=CENTER, so the field is blank for exactly HOLD_CYCLES cycles.
- Arithmetic: pos never wraps; it is bounded to 0..NUM_LEDS-1 by the rules above.

Optional Feature:
- Macro: TUG_FIELD_MATCH_LIMIT_EN
- Defined:
  - Internal 3-bit win tallies for each side, reset to 0.
  - A tally increments on its win pulse.
  - When a tally reaches 7 (matching the counter's saturation at seven), HOLD exits to LOCKED instead of PLAY.
  - LOCKED: leds=0, edge_armed=0, game_over=1, L/R ignored, until reset.
- Undefined: no tallies; state never enters LOCKED; game_over tied 0.

Test Plan:
- Reset then idle 5 cycles -> leds=9'b000010000, edge_armed=0, side=0, no win pulses.
- 4 R pulses from reset -> pos=0, leds=9'b000000001, edge_armed=1, side=1. The 5th R -> win_r pulses 1 cycle; the same cycle shows edge_armed=1 & side=1; the field is blank for 4 cycles, then leds=9'b000010000.
- 4 L pulses then L+R together -> pos stays 8, leds=9'b100000000, edge_armed=1, side=0, no win. A following single L -> win_l for 1 cycle.
- Light at pos 0 (armed right), L pulse -> pos=1, edge_armed=0, no win.
- Win_r, then R held high during all 4 HOLD cycles -> no second win_r, pos unaffected, re-centres at 4. Assert reset in HOLD cycle 2 -> next cycle PLAY, leds=one-hot 4.
- With TUG_FIELD_MATCH_LIMIT_EN: 7 right wins -> after 7th HOLD, game_over=1, leds=0, L/R ignored; reset clears game_over=0 and leds=one-hot 4.
